serial_add_ctrl: RTL and testbench

Bit-serial adder controller built around one instance of the team's 1-bit full adder `fa_vr` (port order: sum, carry, a, b, c_in). It sequences the adder over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands. A carry flip-flop and shift registers hold the intermediate state. The result is returned through a start/busy/done handshake. It sits between operand sources and any consumer needing a small-area multi-bit adder.

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one fa_vr over WIDTH cycles (LSB first)
// behind a start/busy/done handshake. Define SERIAL_ADD_SUB_EN to add the `sub` port (a - b).

module fa_vr (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-2:0] sh_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             last;

  // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : c_in;
`else
  assign b_load = b;
  assign c_load = c_in;
`endif

  fa_vr u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c_in  (carry)
  );

  // Result bits enter at the MSB end; r_nxt is the full word once the last bit lands.
  assign r_nxt = {fa_sum, sh_r};
  assign last  = (cnt == CW'(WIDTH - 1));

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_r  <= r_nxt[WIDTH-1:1];
          carry <= fa_carry;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= r_nxt;
            c_out <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): expected results queued at start,
// popped and compared when done pulses.

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             c_out;
    logic [WIDTH-1:0] sum;
  } result_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy, done, c_out;
  logic [WIDTH-1:0] sum;

  result_t exp_q[$];
  int      checks      = 0;
  int      errors      = 0;
  int      done_pulses = 0;
  int      overlap     = 0;
  int      pulses_ref;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_pulses++;
    if (busy && done) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse across a rising edge and queue the reference result.
  task automatic start_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                          input logic cc, input bit is_sub);
    logic [WIDTH:0] model;
    @(negedge clk);
    a     = aa;
    b     = bb;
    c_in  = cc;
    start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub   = is_sub;
`endif
    if (is_sub) model = {1'b0, aa} + {1'b0, ~bb} + (WIDTH+1)'(1);
    else        model = {1'b0, aa} + {1'b0, bb} + (WIDTH+1)'(cc);
    exp_q.push_back(model);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare; also check hold.
  task automatic wait_done(input string tag, input int exp_busy, input bit scramble);
    int      n_busy = 0;
    int      cyc    = 0;
    result_t r;
    while (!done && cyc < 40) begin
      if (busy) n_busy++;
      if (scramble) begin
        a    = WIDTH'($urandom);
        b    = WIDTH'($urandom);
        c_in = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ":done_seen"}, {31'b0, done}, 32'd1);
    check({tag, ":busy_cycles"}, n_busy, exp_busy);
    check({tag, ":sb_depth"}, exp_q.size(), 32'd1);
    r = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, ":sum"}, {24'b0, sum}, {24'b0, r.sum});
    check({tag, ":c_out"}, {31'b0, c_out}, {31'b0, r.c_out});
    @(negedge clk);
    check({tag, ":done_one_cycle"}, {31'b0, done}, 32'd0);
    check({tag, ":sum_held"}, {24'b0, sum}, {24'b0, r.sum});
    check({tag, ":c_out_held"}, {31'b0, c_out}, {31'b0, r.c_out});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_sum", {24'b0, sum}, 32'd0);
    check("reset_c_out", {31'b0, c_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Zero operands, nominal latency.
    start_op(8'h00, 8'h00, 1'b0, 1'b0);
    wait_done("t1", 8, 1'b0);

    // Full carry ripple, then carry-in used.
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("t2a", 8, 1'b0);
    start_op(8'h5A, 8'h3C, 1'b1, 1'b0);
    wait_done("t2b", 8, 1'b0);
    repeat (3) @(negedge clk);
    check("t2b:sum_long_hold", {24'b0, sum}, 32'h97);
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done("max", 8, 1'b0);

    // Start during RUN is ignored; only one done pulse.
    pulses_ref = done_pulses;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 5, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    check("t3:single_done", done_pulses - pulses_ref, 32'd1);
    check("t3:idle_after", {31'b0, busy}, 32'd0);

    // Asynchronous reset during RUN discards the operation.
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pulses_ref = done_pulses;
    #2 reset = 1'b1;
    #1;
    check("t4:busy_reset", {31'b0, busy}, 32'd0);
    check("t4:done_reset", {31'b0, done}, 32'd0);
    check("t4:sum_reset", {24'b0, sum}, 32'd0);
    check("t4:c_out_reset", {31'b0, c_out}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("t4:no_done", done_pulses - pulses_ref, 32'd0);
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done("t4", 8, 1'b0);

    // Operand inputs toggled every cycle while running.
    start_op(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done("t5", 8, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("t6a", 8, 1'b0);
    start_op(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done("t6b", 8, 1'b0);
    start_op(8'h21, 8'h10, 1'b1, 1'b0);
    wait_done("t6c", 8, 1'b0);
`endif

    check("busy_done_overlap", overlap, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
